// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (start / DATA_BITS data LSB-first / 1 stop).
// The start bit is confirmed at its middle. Data and stop bits are then sampled
// one full bit period apart. rx_done and frame_err are registered one-clk pulses.
// Optional feature: define UART_RX_SYNC_EN to put a 2-flop synchronizer (reset
// value 1) in front of all receive logic. Every sampling point then moves 2 clk later.
module uart_rx_os #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Line as seen by the receive logic (synchronized or direct).
  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw line into the two-stage synchronizer.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  // Synchronizer flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;

  // Next-state, counter, shift register and output-pulse logic.
  // Without a baud_tick everything holds, except that a low line in IDLE
  // starts a frame on any clk.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            // Middle of the start bit. A high line here was only a glitch.
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            // Middle of a data bit. LSB arrives first, so shift right from the MSB.
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            // Middle of the stop bit. Only a high stop bit publishes the word.
            tick_d  = '0;
            state_d = IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Receiver state and output registers. Reset clears everything, including rx_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port baud_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  serial line, idle high.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last correctly framed word.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse when rx_data is updated.
REQ-009 SHALL have port rx_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse on an invalid stop bit.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP, held in a registered state plus next-state logic.
REQ-012 SHALL keep a tick counter (0..OVERSAMPLE-1) that advances only on baud_tick and clears on every state change.
REQ-013 SHALL keep a bit counter (0..DATA_BITS-1), active in DATA only.
REQ-014 IDLE: on a clk with sampled rx==0, go to START and clear the tick counter; baud_tick is not required.
REQ-015 START: on the baud_tick where the tick counter == OVERSAMPLE/2-1 (mid start bit):
- rx==0 -> DATA, tick and bit counters cleared.
- rx==1 -> IDLE (glitch rejected), with no output pulse.
REQ-016 DATA: on the baud_tick where the tick counter == OVERSAMPLE-1, sample rx into a shift register LSB-first (new bit enters the MSB, shifting right).
- bit counter == DATA_BITS-1 -> STOP.
- otherwise increment the bit counter.
REQ-017 STOP: on the baud_tick where the tick counter == OVERSAMPLE-1, sample rx and go to IDLE.
- rx==1 -> load rx_data from the shift register; pulse rx_done for exactly one clk.
- rx==0 -> pulse frame_err for one clk; rx_data stays unchanged.
REQ-018 rx_done and frame_err SHALL be registered and assert on the clk after the qualifying baud_tick edge; they SHALL never assert together.
REQ-019 rx_data SHALL hold its value until the next valid frame, and is never cleared except by reset.
REQ-020 Frame-error recovery: after a frame error, if rx is still 0 in IDLE, the block SHALL re-enter START and treat the line as a new start (a break yields repeated frame_err).
REQ-021 Back-to-back frames: the block SHALL accept a start edge on the clk immediately after returning to IDLE, with no extra idle bit required.
REQ-022 While baud_tick is held low, all counters and state SHALL freeze, except the IDLE->START transition.
REQ-023 All next-state and next-output logic SHALL be fully assigned in every branch, with no inferred latches.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, counters=0, shift register=0, rx_data=0, rx_done=0, frame_err=0, rx_busy=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no rx_done and no frame_err; after release, the block waits for a new falling edge.

Configuration
REQ-026 With macro UART_RX_SYNC_EN defined:
- rx SHALL pass through a 2-flop synchronizer (reset value 1) before all logic.
- Every sampling point shifts 2 clk later.
REQ-027 Without UART_RX_SYNC_EN, rx SHALL feed the logic directly, with no added latency.

Verification
REQ-028 Normal frame: OVERSAMPLE=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_data=0xA5, single rx_done pulse, frame_err=0, rx_busy low afterwards.
REQ-029 Back-to-back: send 0x00 then 0xFF with no idle gap -> two rx_done pulses, rx_data=0x00 then 0xFF.
REQ-030 Glitch: rx low for 4 baud_ticks, then high -> returns to IDLE, no rx_done/frame_err, rx_data unchanged.
REQ-031 Frame error: send 0x3C with stop bit=0 -> one frame_err pulse, no rx_done, rx_data keeps its previous value.
REQ-032 Reset mid-frame: assert rst during bit 3 of 0x81, then send 0x42 -> no output for 0x81, rx_data=0x42 after the second frame.
REQ-033 Macro: with UART_RX_SYNC_EN, repeat REQ-028 -> same data, rx_done delayed by exactly 2 clk relative to the build without the macro.
